// File: rtl/oa_pos_pipe.sv
// Pipelined product-of-sums (OR-AND) evaluator with valid/ready handshakes, runtime group mask and complementary output.
// Optional saturating rise counter on delivered Q, enabled by defining OA_POS_PIPE_RISE_CNT_EN.
module oa_pos_pipe #(
    parameter int GROUPS = 3,
    parameter int GW     = 2,
    parameter int CNT_W  = 8
) (
    input  logic                   CLK,
    input  logic                   RSTB,
    input  logic [GROUPS*GW-1:0]   IN,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic                   MASK_WE,
    input  logic [GROUPS-1:0]      MASK_D,
    output logic                   Q,
    output logic                   QN,
    output logic                   Q_VALID,
    input  logic                   Q_READY,
    output logic [GROUPS-1:0]      GRP_OR,
    output logic [CNT_W-1:0]       RISE_CNT
);

    logic [GROUPS-1:0] mask_q, mask_d;
    logic [GROUPS-1:0] s1_or_q, s1_or_d;
    logic              s1_valid_q, s1_valid_d;
    logic              q_q, q_d;
    logic              qn_q, qn_d;
    logic              q_valid_q, q_valid_d;
    logic [GROUPS-1:0] grp_or_q, grp_or_d;
    logic [GROUPS-1:0] in_or;
    logic              s2_load, s1_load, accept, handshake;

    // A masked group is forced true so it drops out of the final AND.
    generate
        for (genvar gi = 0; gi < GROUPS; gi++) begin : g_or
            assign in_or[gi] = (|IN[gi*GW +: GW]) | mask_q[gi];
        end
    endgenerate

    assign s2_load   = !q_valid_q || Q_READY;
    assign s1_load   = !s1_valid_q || s2_load;
    assign accept    = IN_VALID && s1_load;
    assign handshake = q_valid_q && Q_READY;

    always_comb begin
        mask_d     = mask_q;
        s1_or_d    = s1_or_q;
        s1_valid_d = s1_valid_q;
        q_d        = q_q;
        qn_d       = qn_q;
        q_valid_d  = q_valid_q;
        grp_or_d   = grp_or_q;

        if (MASK_WE) mask_d = MASK_D;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_or_d    = in_or;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s1_valid_q && s2_load) begin
            q_d       = &s1_or_q;
            qn_d      = ~(&s1_or_q);
            grp_or_d  = s1_or_q;
            q_valid_d = 1'b1;
        end else if (Q_READY) begin
            q_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            mask_q     <= '0;
            s1_or_q    <= '0;
            s1_valid_q <= 1'b0;
            q_q        <= 1'b0;
            qn_q       <= 1'b1;
            q_valid_q  <= 1'b0;
            grp_or_q   <= '0;
        end else begin
            mask_q     <= mask_d;
            s1_or_q    <= s1_or_d;
            s1_valid_q <= s1_valid_d;
            q_q        <= q_d;
            qn_q       <= qn_d;
            q_valid_q  <= q_valid_d;
            grp_or_q   <= grp_or_d;
        end
    end

    assign IN_READY = s1_load;
    assign Q        = q_q;
    assign QN       = qn_q;
    assign Q_VALID  = q_valid_q;
    assign GRP_OR   = grp_or_q;

`ifdef OA_POS_PIPE_RISE_CNT_EN
    logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
    logic             last_q_q, last_q_d;

    // Rises are judged on delivered results only, so stalled outputs count once.
    always_comb begin
        rise_cnt_d = rise_cnt_q;
        last_q_d   = last_q_q;
        if (handshake) begin
            last_q_d = q_q;
            if (q_q && !last_q_q && (rise_cnt_q != {CNT_W{1'b1}})) begin
                rise_cnt_d = rise_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            rise_cnt_q <= '0;
            last_q_q   <= 1'b0;
        end else begin
            rise_cnt_q <= rise_cnt_d;
            last_q_q   <= last_q_d;
        end
    end

    assign RISE_CNT = rise_cnt_q;
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
    assign RISE_CNT         = '0;
`endif

endmodule
